change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream stage of the coin-accumulating vending FSM.
- Consumes that FSM's vend result (`i_soda`) and change code (`i_change`, in nickels) and queues them as vend jobs.
- Drives the physical outputs: one timed soda-motor pulse per job, then one timed nickel-ejector pulse per nickel of change.
- Buffers back-to-back vends so the coin FSM never stalls.

Parameters:
PULSE_CYCLES, 4, cycles `o_nickle_eject` stays high per nickel (>=1)
GAP_CYCLES, 2, low cycles after each nickel pulse (>=1)
SODA_CYCLES, 8, cycles `o_soda_motor` stays high per soda (>=1)
FIFO_DEPTH, 4, job queue entries (power of 2, >=2)

Ports:
i_clk  in  1  clock, all flops on rising edge
i_rst  in  1  asynchronous active-high reset
i_soda  in  1  one-cycle vend strobe from coin FSM
i_change  in  3  change owed in nickels (0..7), valid in same cycle as `i_soda` or alone
o_soda_motor  out  1  soda release motor drive
o_nickle_eject  out  1  nickel ejector solenoid drive
o_busy  out  1  FSM not in IDLE, or queue non-empty
o_full  out  1  queue holds FIFO_DEPTH jobs
o_overflow  out  1  sticky: a job was dropped

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
- While `i_rst` is high, all outputs are 0, the FSM is in IDLE and the queue is emptied.
- Reset mid-operation aborts any pulse immediately; no pending jobs survive.
- Job capture: at a rising edge where `i_soda`=1 or `i_change`!=0, push {`i_soda`, `i_change`}. `i_soda`=0 with `i_change`=0 is ignored.
- Push when full: the job is dropped and `o_overflow` is set (cleared only by reset), unless a pop occurs on the same edge. In that case the push succeeds and nothing is dropped.
- Push and pop on the same edge with the queue empty: the push is stored and the pop does not occur (no bypass).
- Counts: occupancy counter is clog2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SODA, EJECT, GAP. All outputs are registered decodes of state.
- IDLE:
  - If the queue is non-empty, pop at the edge and load `soda_f` and `nick_cnt`=change.
  - Go to SODA if `soda_f`; else EJECT if `nick_cnt`>0.
  - A popped job with soda=0 and change=0 cannot exist.
- SODA:
  - `o_soda_motor`=1 for exactly SODA_CYCLES cycles.
  - Then EJECT if `nick_cnt`>0, else IDLE.
- EJECT:
  - `o_nickle_eject`=1 for PULSE_CYCLES cycles.
  - Decrement `nick_cnt` on leaving; then go to GAP.
- GAP:
  - Both drives 0 for GAP_CYCLES cycles.
  - Then EJECT if `nick_cnt`>0, else IDLE.
- Latency:
  - With the queue empty and FSM in IDLE, a job captured at edge N pops at edge N+1.
  - The first drive output is high from edge N+1.
- Next job: IDLE lasts one cycle between jobs (the pop edge), so the next job starts on the edge IDLE is exited.
- Mutual exclusion: `o_soda_motor` and `o_nickle_eject` are never high together.
- Timing: a single phase timer counts down; width is sized to max(PULSE_CYCLES, GAP_CYCLES, SODA_CYCLES).
- Ignored input: `i_change` values with soda=0 are still dispensed (refund of a partial sale).

Optional Feature:
- Macro: DISPENSE_COUNT_EN.
- When defined:
  - Adds output `o_nickle_total` [7:0].
  - Increments by 1 on each EJECT exit; saturates at 255.
  - Reset value 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold `i_rst`=1 during activity, then release → all outputs 0, `o_busy`=0, and no drive pulses follow.
- Single job `i_soda`=1, `i_change`=3 at edge N:
  - `o_soda_motor` high for 8 cycles from edge N+1.
  - Then 3 ejector pulses, each 4 high / 2 low.
  - `o_busy` falls after the last gap.
- Change-only job `i_change`=2, `i_soda`=0 → no motor pulse; 2 ejector pulses start at edge N+1.
- Overflow: push 6 jobs on consecutive edges with default depth 4:
  - First job pops on the second edge, so 5 are held.
  - The 6th job is dropped and `o_overflow`=1.
  - `o_full`=1 until the next pop.
- Push while full on the same edge as a pop → no drop; all jobs eventually dispensed in order.
- With DISPENSE_COUNT_EN, run jobs totaling 300 nickels → `o_nickle_total`=255 (saturated).

Source files
------------

// File: rtl/change_dispenser.sv
// Job queue plus motor/ejector pulse sequencer downstream of the coin FSM.
// Optional DISPENSE_COUNT_EN adds a saturating count of ejected nickels (o_nickle_total).
module change_dispenser #(
   parameter int unsigned PULSE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES   = 2,
   parameter int unsigned SODA_CYCLES  = 8,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_soda,
   input  logic [2:0] i_change,
   output logic       o_soda_motor,
   output logic       o_nickle_eject,
   output logic       o_busy,
   output logic       o_full,
   output logic       o_overflow
`ifdef DISPENSE_COUNT_EN
   ,
   output logic [7:0] o_nickle_total
`endif
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = AW + 1;
   localparam int unsigned TMAX0 = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int unsigned TMAX  = (TMAX0 > SODA_CYCLES) ? TMAX0 : SODA_CYCLES;
   // Timer holds phase length minus one, so clog2(TMAX) bits are enough.
   localparam int unsigned TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StSoda,
      StEject,
      StGap
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      nick_q, nick_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [3:0]      mem_q [FIFO_DEPTH];
   logic [3:0]      mem_d [FIFO_DEPTH];
   logic            motor_q, motor_d;
   logic            eject_q, eject_d;
   logic            busy_q, busy_d;
   logic            full_q, full_d;
   logic            ovf_q, ovf_d;

   logic            push;
   logic            push_ok;
   logic            pop;
   logic            full_now;
   logic [3:0]      head;

   assign push     = i_soda | (i_change != 3'd0);
   assign full_now = (count_q == CW'(FIFO_DEPTH));
   // A pop on the same edge frees the slot, so a push into a full queue still lands.
   assign push_ok  = push & (~full_now | pop);
   assign head     = mem_q[rptr_q];

   // Queue bookkeeping.
   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      ovf_d   = ovf_q | (push & ~push_ok);
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push_ok) begin
         mem_d[wptr_q] = {i_soda, i_change};
         wptr_d        = wptr_q + AW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Sequencer: a pop only happens from IDLE with a non-empty queue, so there is no bypass.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      nick_d  = nick_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               pop    = 1'b1;
               nick_d = head[2:0];
               if (head[3]) begin
                  state_d = StSoda;
                  timer_d = TW'(SODA_CYCLES - 1);
               end else if (head[2:0] != 3'd0) begin
                  state_d = StEject;
                  timer_d = TW'(PULSE_CYCLES - 1);
               end
            end
         end
         StSoda: begin
            if (timer_q == '0) begin
               if (nick_q != 3'd0) begin
                  state_d = StEject;
                  timer_d = TW'(PULSE_CYCLES - 1);
               end else begin
                  state_d = StIdle;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         StEject: begin
            if (timer_q == '0) begin
               nick_d  = nick_q - 3'd1;
               state_d = StGap;
               timer_d = TW'(GAP_CYCLES - 1);
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         StGap: begin
            if (timer_q == '0) begin
               if (nick_q != 3'd0) begin
                  state_d = StEject;
                  timer_d = TW'(PULSE_CYCLES - 1);
               end else begin
                  state_d = StIdle;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state so a drive rises on the edge its phase starts.
   always_comb begin
      motor_d = (state_d == StSoda);
      eject_d = (state_d == StEject);
      busy_d  = (state_d != StIdle) || (count_d != '0);
      full_d  = (count_d == CW'(FIFO_DEPTH));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         timer_q <= '0;
         nick_q  <= '0;
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         motor_q <= 1'b0;
         eject_q <= 1'b0;
         busy_q  <= 1'b0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         nick_q  <= nick_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         motor_q <= motor_d;
         eject_q <= eject_d;
         busy_q  <= busy_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign o_soda_motor   = motor_q;
   assign o_nickle_eject = eject_q;
   assign o_busy         = busy_q;
   assign o_full         = full_q;
   assign o_overflow     = ovf_q;

`ifdef DISPENSE_COUNT_EN
   logic [7:0] total_q, total_d;

   always_comb begin
      total_d = total_q;
      if ((state_q == StEject) && (timer_q == '0) && (total_q != 8'hFF)) begin
         total_d = total_q + 8'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         total_q <= '0;
      end else begin
         total_q <= total_d;
      end
   end

   assign o_nickle_total = total_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: per-job waveform vectors plus queue/overflow sequences.
module tb_change_dispenser;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       soda   = 1'b0;
   logic [2:0] change = 3'd0;
   logic       motor, eject, busy, full, ovf;
`ifdef DISPENSE_COUNT_EN
   logic [7:0] total;
`endif

   change_dispenser dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_soda         (soda),
      .i_change       (change),
      .o_soda_motor   (motor),
      .o_nickle_eject (eject),
      .o_busy         (busy),
      .o_full         (full),
      .o_overflow     (ovf)
`ifdef DISPENSE_COUNT_EN
      ,
      .o_nickle_total (total)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive activity recorder: motor rise shifts in 2'b10, ejector rise shifts in 2'b01.
   logic [63:0] ev_code;
   int          ev_n, mot_hi, ej_hi, ej_rise, busy_hi;
   int          both_hi = 0;
   logic        prev_m, prev_e;

   task automatic rec_clear();
      ev_code = '0;
      ev_n    = 0;
      mot_hi  = 0;
      ej_hi   = 0;
      ej_rise = 0;
      busy_hi = 0;
      prev_m  = motor;
      prev_e  = eject;
   endtask

   task automatic observe();
      if (motor && !prev_m) begin
         ev_code = {ev_code[61:0], 2'b10};
         ev_n++;
      end
      if (eject && !prev_e) begin
         ev_code = {ev_code[61:0], 2'b01};
         ev_n++;
         ej_rise++;
      end
      if (motor) mot_hi++;
      if (eject) ej_hi++;
      if (busy) busy_hi++;
      if (motor && eject) both_hi++;
      prev_m = motor;
      prev_e = eject;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // first: 1 = motor first, 2 = ejector first, on the cycle after the pop edge
   typedef struct {
      logic       soda;
      logic [2:0] ch;
      int         motor_cyc;
      int         eject_cyc;
      int         pulses;
      int         busy_cyc;
      int         first;
   } vec_t;

   typedef struct {
      logic       soda;
      logic [2:0] ch;
      int         at;
      logic       acc;
   } job_t;

   vec_t        vecs [6];
   job_t        seq_jobs [6];
   logic        fullv [300];
   logic        ovfv [300];
   logic [63:0] exp_code;
   int          exp_n;

   task automatic run_seq();
      rec_clear();
      for (int e = 0; e < 300; e++) begin
         soda   = 1'b0;
         change = 3'd0;
         for (int j = 0; j < 6; j++) begin
            if (seq_jobs[j].at == e) begin
               soda   = seq_jobs[j].soda;
               change = seq_jobs[j].ch;
            end
         end
         step();
         soda   = 1'b0;
         change = 3'd0;
         observe();
         fullv[e] = full;
         ovfv[e]  = ovf;
      end
      exp_code = '0;
      exp_n    = 0;
      for (int j = 0; j < 6; j++) begin
         if (seq_jobs[j].acc) begin
            if (seq_jobs[j].soda) begin
               exp_code = {exp_code[61:0], 2'b10};
               exp_n++;
            end
            for (int c = 0; c < int'(seq_jobs[j].ch); c++) begin
               exp_code = {exp_code[61:0], 2'b01};
               exp_n++;
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int first;
      int ff;

      //            soda  ch    mot ej  pul busy first
      vecs[0] = '{1'b1, 3'd3, 8,  12, 3,  27,  1};
      vecs[1] = '{1'b0, 3'd2, 0,  8,  2,  13,  2};
      vecs[2] = '{1'b1, 3'd0, 8,  0,  0,  9,   1};
      vecs[3] = '{1'b0, 3'd7, 0,  28, 7,  43,  2};
      vecs[4] = '{1'b1, 3'd7, 8,  28, 7,  51,  1};
      vecs[5] = '{1'b0, 3'd1, 0,  4,  1,  7,   2};

      // Activity while reset is held must be ignored.
      soda   = 1'b1;
      change = 3'd5;
      step();
      step();
      step();
      check("rst_motor", motor, 0);
      check("rst_eject", eject, 0);
      check("rst_busy", busy, 0);
      check("rst_full", full, 0);
      check("rst_ovf", ovf, 0);
`ifdef DISPENSE_COUNT_EN
      check("rst_total", total, 0);
`endif
      soda   = 1'b0;
      change = 3'd0;
      rst    = 1'b0;
      rec_clear();
      for (int k = 0; k < 20; k++) begin
         step();
         observe();
      end
      check("post_rst_drive", mot_hi + ej_hi, 0);
      check("post_rst_busy", busy_hi, 0);

      // Reset in the middle of a soda pulse with jobs still queued.
      for (int j = 0; j < 3; j++) begin
         soda   = 1'b1;
         change = 3'd3;
         step();
      end
      soda   = 1'b0;
      change = 3'd0;
      step();
      step();
      check("pre_abort_motor", motor, 1);
      #3;
      rst = 1'b1;
      #1;
      check("abort_motor", motor, 0);
      check("abort_busy", busy, 0);
      step();
      step();
      rst = 1'b0;
      rec_clear();
      for (int k = 0; k < 80; k++) begin
         step();
         observe();
      end
      check("abort_no_drive", mot_hi + ej_hi, 0);
      check("abort_no_busy", busy_hi, 0);

      // Single jobs into an idle dispenser.
      for (int v = 0; v < 6; v++) begin
         soda   = vecs[v].soda;
         change = vecs[v].ch;
         step();
         soda   = 1'b0;
         change = 3'd0;
         rec_clear();
         busy_hi = busy ? 1 : 0;
         first   = 0;
         for (int k = 1; k <= 70; k++) begin
            step();
            observe();
            if (k == 1) first = motor ? 1 : (eject ? 2 : 0);
         end
         check($sformatf("v%0d_motor_cycles", v), mot_hi, vecs[v].motor_cyc);
         check($sformatf("v%0d_eject_cycles", v), ej_hi, vecs[v].eject_cyc);
         check($sformatf("v%0d_pulses", v), ej_rise, vecs[v].pulses);
         check($sformatf("v%0d_busy_cycles", v), busy_hi, vecs[v].busy_cyc);
         check($sformatf("v%0d_first_drive", v), first, vecs[v].first);
      end

      // Overflow: six pushes on consecutive edges, the sixth is dropped.
      do_reset();
      seq_jobs[0] = '{1'b1, 3'd1, 0, 1'b1};
      seq_jobs[1] = '{1'b0, 3'd2, 1, 1'b1};
      seq_jobs[2] = '{1'b1, 3'd0, 2, 1'b1};
      seq_jobs[3] = '{1'b0, 3'd3, 3, 1'b1};
      seq_jobs[4] = '{1'b1, 3'd2, 4, 1'b1};
      seq_jobs[5] = '{1'b0, 3'd1, 5, 1'b0};
      run_seq();
      check("ovf_full_e3", fullv[3], 0);
      check("ovf_full_e4", fullv[4], 1);
      check("ovf_flag_e4", ovfv[4], 0);
      check("ovf_full_e5", fullv[5], 1);
      check("ovf_flag_e5", ovfv[5], 1);
      ff = -1;
      for (int e = 6; e < 300; e++) begin
         if (ff < 0 && fullv[e] == 1'b0) ff = e;
      end
      check("ovf_full_fall_edge", ff, 16);
      check("ovf_sticky", ovf, 1);
      check64("ovf_order", ev_code, exp_code);
      check("ovf_event_count", ev_n, exp_n);
      check("ovf_idle_end", busy, 0);

      // Push into a full queue on the pop edge: nothing dropped.
      do_reset();
      seq_jobs[5] = '{1'b0, 3'd1, 16, 1'b1};
      run_seq();
      check("pp_full_e15", fullv[15], 1);
      check("pp_full_e16", fullv[16], 1);
      check("pp_ovf_e16", ovfv[16], 0);
      check("pp_ovf_end", ovf, 0);
      check64("pp_order", ev_code, exp_code);
      check("pp_event_count", ev_n, exp_n);
      check("pp_idle_end", busy, 0);

`ifdef DISPENSE_COUNT_EN
      // 42 jobs of 7 plus one of 6 = 300 nickels; counter saturates at 255.
      do_reset();
      check("cnt_reset", total, 0);
      for (int j = 0; j < 43; j++) begin
         change = (j < 42) ? 3'd7 : 3'd6;
         step();
         change = 3'd0;
         for (int k = 0; k < 100; k++) begin
            step();
            if (!busy) break;
         end
         check($sformatf("cnt_job%0d_done", j), busy, 0);
         if (j == 0) check("cnt_after_first", total, 7);
      end
      check("cnt_saturated", total, 255);
`endif

      check("mutual_exclusion", both_hi, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
